uart_cmd_master: RTL and testbench
==================================

UART_CMD_MASTER -- requirements
Module: uart_cmd_master

Interface
REQ-001 SHALL provide parameter WR_BITS, default 128: write payload width in bits, multiple of 8, >=16.
REQ-002 SHALL provide parameter RD_BITS, default 128: read payload width in bits, multiple of 8, >=16.
REQ-003 SHALL provide parameter TIMEOUT, default 1000000: max clk cycles between received read bytes, >=2.
REQ-004 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports req_valid in 1 / req_ready out 1: request handshake.
REQ-007 SHALL have port req_op  in  2  opcode: 0 WRITE, 1 READ, 2 SWRST, 3 RUN.
REQ-008 SHALL have port req_addr  in  8  target BRAM address (WRITE/READ only).
REQ-009 SHALL have port req_wdata  in  WR_BITS  write payload.
REQ-010 SHALL have ports rsp_valid out 1 (one-cycle pulse), rsp_err out 1, rsp_rdata out RD_BITS.
REQ-011 SHALL have ports byte_tx_data out 8, byte_tx_valid out 1, byte_tx_ready in 1: bytes to UART transmitter.
REQ-012 SHALL have ports byte_rx_data in 8, byte_rx_valid in 1: one-cycle strobe per byte from UART receiver.
REQ-013 SHALL have port busy  out  1  high whenever state != IDLE.

Function
REQ-014 SHALL implement states IDLE, SEND_CMD, SEND_ADDR, SEND_DATA, RECV_DATA, DONE.
REQ-015 SHALL assert req_ready only in IDLE; on req_valid&req_ready latch op, addr, wdata and enter SEND_CMD next cycle.
REQ-016 SHALL treat a tx byte as transferred only on byte_tx_valid&byte_tx_ready; byte_tx_data stable while valid high and not accepted.
REQ-017 SEND_CMD SHALL emit command byte 0x10 WRITE, 0x20 READ, 0x30 SWRST, 0x40 RUN.
REQ-018 After command accepted: WRITE/READ -> SEND_ADDR; SWRST/RUN -> DONE.
REQ-019 SEND_ADDR SHALL emit latched addr; on acceptance WRITE -> SEND_DATA, READ -> RECV_DATA.
REQ-020 SEND_DATA SHALL emit WR_BITS/8 bytes, least-significant first (first = wdata[7:0], last = wdata[WR_BITS-1:WR_BITS-8]); after last acceptance -> DONE.
REQ-021 byte_tx_valid MAY deassert for at most one cycle between bytes; no bytes in IDLE, RECV_DATA, DONE.
REQ-022 RECV_DATA SHALL capture RD_BITS/8 bytes, first received = rdata MSB byte, shift-left-insert at LSB; after last byte -> DONE.
REQ-023 Byte counters SHALL be sized ceil(log2(N+1)); no wrap within one transfer.
REQ-024 byte_rx_valid outside RECV_DATA SHALL be discarded without state change.
REQ-025 Timeout counter SHALL clear on entry to RECV_DATA and on every received byte; reaching TIMEOUT cycles -> DONE with error.
REQ-026 DONE SHALL last one cycle: rsp_valid=1, rsp_err=1 only for timeout, rsp_rdata = captured data for successful READ, else 0; -> IDLE.
REQ-027 rsp_rdata and rsp_err SHALL hold value until next DONE; rsp_valid low otherwise.
REQ-028 Received byte on same cycle as timeout expiry SHALL win (byte captured, counter cleared).
REQ-029 Latency: rsp_valid SHALL rise the cycle after final byte handshake/receipt.

Reset
REQ-030 rst_n low SHALL force state IDLE, counters 0, req_ready 1 on next cycle after release-synchronous sample, byte_tx_valid 0, byte_tx_data 0, rsp_valid 0, rsp_err 0, rsp_rdata 0, busy 0.
REQ-031 Reset mid-operation SHALL abandon transfer immediately; no response pulse issued for the aborted request.

Verification
REQ-032 WRITE addr 0x05, WR_BITS=128, wdata=0x0F0E..0100, tx_ready always 1 -> bytes 10,05,00,01,..,0F; rsp_valid, rsp_err=0.
REQ-033 READ addr 0x0A, receiver feeds 16 bytes A0..AF -> tx bytes 20,0A; rsp_rdata=0xA0A1..AF, rsp_err=0.
REQ-034 SWRST then RUN back-to-back -> bytes 30 then 40, two rsp_valid pulses, rsp_rdata=0.
REQ-035 byte_tx_ready low 20 cycles mid-WRITE -> byte_tx_data/valid held stable, no byte lost or duplicated.
REQ-036 READ with TIMEOUT=50, only 3 bytes supplied -> rsp_valid with rsp_err=1, rsp_rdata=0, state IDLE; stray rx byte in IDLE ignored.
REQ-037 rst_n low during SEND_DATA byte 7 -> all outputs reset values, no rsp_valid, next WRITE completes normally.

Source files
------------

// File: rtl/uart_cmd_master.sv
// Command master for a UART-attached BRAM target: serialises WRITE/READ/SWRST/RUN
// requests into tx bytes, collects read payloads from rx bytes, and reports one response per request.
module uart_cmd_master #(
  parameter int unsigned WR_BITS = 128,
  parameter int unsigned RD_BITS = 128,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [7:0]         req_addr,
  input  logic [WR_BITS-1:0] req_wdata,
  output logic               rsp_valid,
  output logic               rsp_err,
  output logic [RD_BITS-1:0] rsp_rdata,
  output logic [7:0]         byte_tx_data,
  output logic               byte_tx_valid,
  input  logic               byte_tx_ready,
  input  logic [7:0]         byte_rx_data,
  input  logic               byte_rx_valid,
  output logic               busy
);

  localparam int unsigned WR_BYTES = WR_BITS / 8;
  localparam int unsigned RD_BYTES = RD_BITS / 8;
  localparam int unsigned WCNT_W   = $clog2(WR_BYTES + 1);
  localparam int unsigned RCNT_W   = $clog2(RD_BYTES + 1);
  localparam int unsigned TMR_W    = $clog2(TIMEOUT + 1);

  localparam logic [WCNT_W-1:0] WR_LAST  = WCNT_W'(WR_BYTES - 1);
  localparam logic [RCNT_W-1:0] RD_LAST  = RCNT_W'(RD_BYTES - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_SWRST = 2'd2;
  localparam logic [1:0] OP_RUN   = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD,
    SEND_ADDR,
    SEND_DATA,
    RECV_DATA,
    DONE
  } state_t;

  state_t             state_q;
  logic [1:0]         op_q;
  logic [7:0]         addr_q;
  logic [WR_BITS-1:0] wdata_q;
  logic [RD_BITS-1:0] rdata_q;
  logic [WCNT_W-1:0]  wcnt_q;
  logic [RCNT_W-1:0]  rcnt_q;
  logic [TMR_W-1:0]   tmr_q;
  logic               req_ready_q;
  logic               busy_q;
  logic [7:0]         tx_data_q;
  logic               tx_valid_q;
  logic               rsp_valid_q;
  logic               rsp_err_q;
  logic [RD_BITS-1:0] rsp_rdata_q;

  logic               tx_hs;
  logic [RD_BITS-1:0] rdata_shift;

  assign tx_hs       = tx_valid_q & byte_tx_ready;
  assign rdata_shift = {rdata_q[RD_BITS-9:0], byte_rx_data};

  assign req_ready     = req_ready_q;
  assign busy          = busy_q;
  assign byte_tx_data  = tx_data_q;
  assign byte_tx_valid = tx_valid_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_rdata     = rsp_rdata_q;

  function automatic logic [7:0] cmd_byte(input logic [1:0] op);
    case (op)
      OP_WRITE: return 8'h10;
      OP_READ:  return 8'h20;
      OP_SWRST: return 8'h30;
      default:  return 8'h40;
    endcase
  endfunction

  // Main sequencer; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_WRITE;
      addr_q      <= 8'h00;
      wdata_q     <= '0;
      rdata_q     <= '0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      tmr_q       <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            op_q        <= req_op;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            tx_data_q   <= cmd_byte(req_op);
            tx_valid_q  <= 1'b1;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= SEND_CMD;
          end
        end
        SEND_CMD: begin
          if (tx_hs) begin
            if (op_q == OP_WRITE || op_q == OP_READ) begin
              tx_data_q <= addr_q;
              state_q   <= SEND_ADDR;
            end else begin
              tx_valid_q  <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= '0;
              state_q     <= DONE;
            end
          end
        end
        SEND_ADDR: begin
          if (tx_hs) begin
            if (op_q == OP_WRITE) begin
              tx_data_q <= wdata_q[7:0];
              wdata_q   <= {8'h00, wdata_q[WR_BITS-1:8]};
              wcnt_q    <= '0;
              state_q   <= SEND_DATA;
            end else begin
              tx_valid_q <= 1'b0;
              rdata_q    <= '0;
              rcnt_q     <= '0;
              tmr_q      <= '0;
              state_q    <= RECV_DATA;
            end
          end
        end
        SEND_DATA: begin
          // wdata_q is pre-shifted so its low byte is always the next one to send
          if (tx_hs) begin
            if (wcnt_q == WR_LAST) begin
              tx_valid_q  <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= '0;
              state_q     <= DONE;
            end else begin
              wcnt_q    <= wcnt_q + WCNT_W'(1);
              tx_data_q <= wdata_q[7:0];
              wdata_q   <= {8'h00, wdata_q[WR_BITS-1:8]};
            end
          end
        end
        RECV_DATA: begin
          // A byte arriving on the expiry cycle takes priority over the timeout
          if (byte_rx_valid) begin
            rdata_q <= rdata_shift;
            tmr_q   <= '0;
            if (rcnt_q == RD_LAST) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= rdata_shift;
              state_q     <= DONE;
            end else begin
              rcnt_q <= rcnt_q + RCNT_W'(1);
            end
          end else if (tmr_q == TMR_LAST) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= DONE;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        DONE: begin
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          tx_valid_q  <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Scoreboard bench for uart_cmd_master: stimulus queues expected tx bytes and
// responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_uart_cmd_master;

  localparam int unsigned WR_BITS = 128;
  localparam int unsigned RD_BITS = 128;
  localparam int unsigned TIMEOUT = 50;

  typedef struct packed {
    logic         err;
    logic [127:0] rdata;
  } rsp_t;

  logic               clk;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_op;
  logic [7:0]         req_addr;
  logic [WR_BITS-1:0] req_wdata;
  logic               rsp_valid;
  logic               rsp_err;
  logic [RD_BITS-1:0] rsp_rdata;
  logic [7:0]         byte_tx_data;
  logic               byte_tx_valid;
  logic               byte_tx_ready;
  logic [7:0]         byte_rx_data;
  logic               byte_rx_valid;
  logic               busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_tx[$];
  rsp_t       exp_rsp[$];

  uart_cmd_master #(
    .WR_BITS(WR_BITS),
    .RD_BITS(RD_BITS),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_err      (rsp_err),
    .rsp_rdata    (rsp_rdata),
    .byte_tx_data (byte_tx_data),
    .byte_tx_valid(byte_tx_valid),
    .byte_tx_ready(byte_tx_ready),
    .byte_rx_data (byte_rx_data),
    .byte_rx_valid(byte_rx_valid),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: tx handshakes, stall stability and response pulses
  initial begin
    logic       stall_q;
    logic [7:0] prev_data;
    logic [7:0] e;
    rsp_t       r;
    stall_q   = 1'b0;
    prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          chk("tx_hold_valid", 128'(byte_tx_valid), 128'(1'b1));
          chk("tx_hold_data", 128'(byte_tx_data), 128'(prev_data));
        end
        if (byte_tx_valid && byte_tx_ready) begin
          if (exp_tx.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL tx_unexpected: got byte %0h expected none", byte_tx_data);
          end else begin
            e = exp_tx.pop_front();
            chk("tx_byte", 128'(byte_tx_data), 128'(e));
          end
        end
        stall_q   = byte_tx_valid && !byte_tx_ready;
        prev_data = byte_tx_data;
        if (rsp_valid) begin
          if (exp_rsp.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rsp_unexpected: got err=%0b rdata=%0h expected no response", rsp_err, rsp_rdata);
          end else begin
            r = exp_rsp.pop_front();
            chk("rsp_err", 128'(rsp_err), 128'(r.err));
            chk("rsp_rdata", rsp_rdata, r.rdata);
          end
        end
      end
    end
  end

  // Issue a request and queue its cmd/addr/first ndata write bytes
  task automatic issue(input logic [1:0] op, input logic [7:0] addr,
                       input logic [127:0] wd, input int ndata);
    int guard = 0;
    while (!req_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL req_ready_wait: got 0 expected 1 within 200 cycles");
    end
    case (op)
      2'd0: exp_tx.push_back(8'h10);
      2'd1: exp_tx.push_back(8'h20);
      2'd2: exp_tx.push_back(8'h30);
      default: exp_tx.push_back(8'h40);
    endcase
    if (op == 2'd0 || op == 2'd1) exp_tx.push_back(addr);
    for (int i = 0; i < ndata; i++) exp_tx.push_back(wd[8*i +: 8]);
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int guard = 0;
    while ((exp_tx.size() != 0 || exp_rsp.size() != 0) && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_tx.size() != 0 || exp_rsp.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got %0d tx/%0d rsp pending expected 0/0",
               name, exp_tx.size(), exp_rsp.size());
      exp_tx.delete();
      exp_rsp.delete();
    end
  endtask

  task automatic wait_tx_empty();
    int guard = 0;
    while (exp_tx.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    #1;
    if (exp_tx.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL tx_drain: got %0d pending expected 0", exp_tx.size());
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    byte_rx_data  = b;
    byte_rx_valid = 1'b1;
    @(posedge clk); #1;
    byte_rx_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_busy"}, 128'(busy), 128'(1'b0));
    chk({name, "_req_ready"}, 128'(req_ready), 128'(1'b1));
    chk({name, "_tx_valid"}, 128'(byte_tx_valid), 128'(1'b0));
  endtask

  task automatic chk_reset_outputs(input string name);
    chk_idle(name);
    chk({name, "_tx_data"}, 128'(byte_tx_data), 128'(8'h00));
    chk({name, "_rsp_valid"}, 128'(rsp_valid), 128'(1'b0));
    chk({name, "_rsp_err"}, 128'(rsp_err), 128'(1'b0));
    chk({name, "_rsp_rdata"}, rsp_rdata, 128'h0);
  endtask

  localparam logic [127:0] W1 = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] W2 = 128'h112233445566778899AABBCCDDEEFF00;
  localparam logic [127:0] R1 = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;

  initial begin
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_op        = 2'd0;
    req_addr      = 8'h00;
    req_wdata     = '0;
    byte_tx_ready = 1'b1;
    byte_rx_data  = 8'h00;
    byte_rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // WRITE addr 0x05, bytes 00..0F LSB first
    exp_rsp.push_back('{err: 1'b0, rdata: 128'h0});
    issue(2'd0, 8'h05, W1, 16);
    wait_done("write1");
    chk_idle("after_write1");

    // READ addr 0x0A, receiver supplies A0..AF
    exp_rsp.push_back('{err: 1'b0, rdata: R1});
    issue(2'd1, 8'h0A, '0, 0);
    wait_tx_empty();
    for (int i = 0; i < 16; i++) send_rx(8'hA0 + 8'(i));
    wait_done("read1");
    chk_idle("after_read1");
    chk("read1_hold_rdata", rsp_rdata, R1);

    // SWRST then RUN back-to-back
    exp_rsp.push_back('{err: 1'b0, rdata: 128'h0});
    exp_rsp.push_back('{err: 1'b0, rdata: 128'h0});
    issue(2'd2, 8'h00, '0, 0);
    issue(2'd3, 8'h00, '0, 0);
    wait_done("swrst_run");

    // WRITE with a 20-cycle tx stall mid-payload
    exp_rsp.push_back('{err: 1'b0, rdata: 128'h0});
    issue(2'd0, 8'h7E, W2, 16);
    while (exp_tx.size() > 10) @(posedge clk);
    #1;
    byte_tx_ready = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    byte_tx_ready = 1'b1;
    wait_done("write_stall");

    // READ timing out after 3 bytes
    exp_rsp.push_back('{err: 1'b1, rdata: 128'h0});
    issue(2'd1, 8'h22, '0, 0);
    wait_tx_empty();
    send_rx(8'h5A);
    send_rx(8'h5B);
    send_rx(8'h5C);
    wait_done("read_timeout");
    chk_idle("after_timeout");
    chk("timeout_hold_err", 128'(rsp_err), 128'(1'b1));

    // Stray rx byte in IDLE must be ignored
    send_rx(8'hEE);
    repeat (3) @(posedge clk);
    #1;
    chk_idle("stray_rx");

    // Reset while byte 7 of a WRITE payload is presented
    byte_tx_ready = 1'b0;
    issue(2'd0, 8'h33, W1, 7);
    for (int i = 0; i < 9; i++) begin
      byte_tx_ready = 1'b1;
      @(posedge clk); #1;
      byte_tx_ready = 1'b0;
      @(posedge clk); #1;
    end
    chk("pre_reset_tx_valid", 128'(byte_tx_valid), 128'(1'b1));
    chk("pre_reset_tx_data", 128'(byte_tx_data), 128'(8'h07));
    chk("pre_reset_busy", 128'(busy), 128'(1'b1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("mid_reset");
    rst_n         = 1'b1;
    byte_tx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk_idle("post_reset");
    chk("post_reset_queue", 128'(exp_tx.size()), 128'(0));

    // Normal WRITE after the aborted one
    exp_rsp.push_back('{err: 1'b0, rdata: 128'h0});
    issue(2'd0, 8'h44, W2, 16);
    wait_done("write_after_reset");
    chk_idle("final");

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before 2000000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
